key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 105 ++++++++++
 tb/tb_key_debounce.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces an active-low push-button.
// Ports:
//   sys_clk     - system clock
//   sys_rst     - asynchronous active-high reset
//   key_in      - raw button pin, asynchronous, idles high, low when pressed
//   key_out     - registered debounced level, idles high
//   key_press   - one-cycle strobe on an accepted 1->0 change
//   key_release - one-cycle strobe on an accepted 0->1 change
module key_debounce #(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {S_UP, S_DN_WAIT, S_DOWN, S_UP_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, key_s_q;
    logic             key_out_q, key_out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q   <= 1'b1;
            key_s_q   <= 1'b1;
            state_q   <= S_UP;
            cnt_q     <= '0;
            key_out_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_in;
            key_s_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // A wait state accepts the new level only if key_s is still opposite on
    // the edge where cnt reaches its last value; any earlier return aborts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_out_d = key_out_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_UP: begin
                if (!key_s_q) begin
                    state_d = S_DN_WAIT;
                    cnt_d   = '0;
                end
            end
            S_DN_WAIT: begin
                if (key_s_q) begin
                    state_d = S_UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DOWN;
                    key_out_d = 1'b0;
                    press_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DOWN: begin
                if (key_s_q) begin
                    state_d = S_UP_WAIT;
                    cnt_d   = '0;
                end
            end
            S_UP_WAIT: begin
                if (!key_s_q) begin
                    state_d = S_DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_UP;
                    key_out_d = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_UP;
                cnt_d     = '0;
                key_out_d = 1'b1;
            end
        endcase
    end

    assign key_out     = key_out_q;
    assign key_press   = press_q;
    assign key_release = release_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: self-checking bench for key_debounce with CNT_MAX=4.
module tb_key_debounce;
    localparam int CNT_MAX = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_out, key_press, key_release;

    key_debounce #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #10 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference: key_s is key_in two edges late; the level flips once key_s
    // has differed from the output on CNT_MAX+1 consecutive edges.
    logic m_s1, m_ks, m_out;
    int   m_run;
    logic [2:0] exp_q[$];

    typedef struct {
        logic kin;
        int   n;
        logic out;
        int   np;
        int   nr;
    } seg_t;
    seg_t segs[17];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b1;
        m_ks  = 1'b1;
        m_out = 1'b1;
        m_run = 0;
        exp_q.delete();
    endtask

    // Called at a negedge; drives key_in, predicts the next edge, checks it.
    task automatic step(input logic k);
        logic nks, pr, rl;
        logic [2:0] e;
        key_in = k;
        pr  = 1'b0;
        rl  = 1'b0;
        nks = m_s1;
        m_s1 = k;
        if (m_ks != m_out) begin
            m_run++;
            if (m_run == CNT_MAX + 1) begin
                m_out = ~m_out;
                m_run = 0;
                pr = ~m_out;
                rl = m_out;
            end
        end else begin
            m_run = 0;
        end
        m_ks = nks;
        exp_q.push_back({m_out, pr, rl});
        @(posedge sys_clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("out_press_release", int'({key_out, key_press, key_release}), int'(e));
        end
        @(negedge sys_clk);
    endtask

    task automatic chk_idle(input string nm);
        chk(nm, int'({key_out, key_press, key_release}), 3'b100);
    endtask

    initial begin
        int np, nr, idx;
        segs[0]  = '{1'b1, 4,  1'b1, 0, 0};
        segs[1]  = '{1'b0, 20, 1'b0, 1, 0};
        segs[2]  = '{1'b1, 20, 1'b1, 0, 1};
        segs[3]  = '{1'b0, 3,  1'b1, 0, 0};
        segs[4]  = '{1'b1, 1,  1'b1, 0, 0};
        segs[5]  = '{1'b0, 2,  1'b1, 0, 0};
        segs[6]  = '{1'b1, 8,  1'b1, 0, 0};
        segs[7]  = '{1'b0, 20, 1'b0, 1, 0};
        segs[8]  = '{1'b1, 3,  1'b0, 0, 0};
        segs[9]  = '{1'b0, 1,  1'b0, 0, 0};
        segs[10] = '{1'b1, 2,  1'b0, 0, 0};
        segs[11] = '{1'b0, 8,  1'b0, 0, 0};
        segs[12] = '{1'b1, 20, 1'b1, 0, 1};
        segs[13] = '{1'b0, 4,  1'b1, 0, 0};
        segs[14] = '{1'b1, 8,  1'b1, 0, 0};
        segs[15] = '{1'b0, 5,  1'b1, 0, 0};
        segs[16] = '{1'b1, 20, 1'b1, 1, 1};

        repeat (3) @(posedge sys_clk);
        #1;
        chk_idle("reset_values");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();

        for (int s = 0; s < 17; s++) begin
            np = 0;
            nr = 0;
            for (int c = 0; c < segs[s].n; c++) begin
                step(segs[s].kin);
                np += int'(key_press);
                nr += int'(key_release);
            end
            chk($sformatf("seg%0d_key_out", s), int'(key_out), int'(segs[s].out));
            chk($sformatf("seg%0d_presses", s), np, segs[s].np);
            chk($sformatf("seg%0d_releases", s), nr, segs[s].nr);
        end

        for (int c = 0; c < 10; c++) step(1'b0);
        chk("pressed_before_reset", int'(key_out), 0);
        #3;
        sys_rst = 1'b1;
        #1;
        chk_idle("async_reset_mid_cycle");
        for (int c = 0; c < 5; c++) begin
            @(posedge sys_clk);
            #1;
            chk_idle("reset_hold");
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();

        for (int c = 0; c < 5; c++) step(1'b0);
        chk("mid_wait_no_press_yet", int'({key_out, key_press}), 2'b10);
        sys_rst = 1'b1;
        #1;
        chk_idle("reset_mid_wait");
        for (int c = 0; c < 3; c++) begin
            @(posedge sys_clk);
            #1;
            chk_idle("reset_mid_wait_hold");
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        idx = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (key_press && idx < 0) idx = i;
        end
        chk("press_edge_after_reset", idx, CNT_MAX + 2);
        chk("key_out_after_reset_press", int'(key_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
